// File: rtl/router_pkg.sv
// router_pkg: shared widths, FSM state codes and header helper for the router packet source
package router_pkg;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam logic [ADDR_W-1:0] DEST_ILLEGAL = 2'd3;

    function automatic logic [DATA_W-1:0] mk_header(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] dest);
        return {len, dest};
    endfunction
endpackage

// File: rtl/router_src_buf.sv
// router_src_buf: 64x8 payload buffer, synchronous write, registered read with write-through
module router_src_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Forward a same-cycle write so the last loaded byte is readable the next cycle
    always_comb begin
        rd_data_d = (we && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
    end

    // Storage array write port
    always_ff @(posedge clock) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Registered read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/router_pkt_src.sv
// router_pkt_src: buffers a descriptor's payload, then streams header/payload/parity to the router
module router_pkt_src
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dest,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              pay_valid,
    output logic              pay_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_done,
    output logic              drop,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] parity_q, parity_d, data_out_q, data_out_d, buf_rd;
    logic              pkt_valid_q, pkt_valid_d, pkt_done_q, pkt_done_d;
    logic              drop_q, drop_d, err_prev_q, err_prev_d, buf_we;
    logic [7:0]        gap_q, gap_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    // rd_ptr_d feeds the buffer so its registered output always holds buffer[rd_ptr_q]
    router_src_buf u_buf (
        .clock   (clock),
        .reset   (reset),
        .we      (buf_we),
        .wr_addr (wr_ptr_q),
        .wr_data (pay_data),
        .rd_addr (rd_ptr_d),
        .rd_data (buf_rd)
    );

    // Next-state logic: rd_ptr counts bytes already moved from the buffer onto data_out
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        dest_d      = dest_q;
        parity_d    = parity_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        gap_d       = gap_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        pkt_done_d  = 1'b0;
        drop_d      = 1'b0;
        buf_we      = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_prev_d  = err;
        err_cnt_d   = err_cnt_q + CNT_W'(err && !err_prev_q);
        case (state_q)
            S_IDLE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                if (req_valid) begin
                    if (req_dest == DEST_ILLEGAL) drop_d = 1'b1;
                    else begin
                        len_d    = req_len;
                        dest_d   = req_dest;
                        parity_d = mk_header(req_len, req_dest);
                        if (req_len == '0) begin
                            state_d     = S_HEADER;
                            data_out_d  = mk_header(req_len, req_dest);
                            pkt_valid_d = 1'b1;
                        end else state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pay_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + LEN_W'(1);
                    parity_d = parity_q ^ pay_data;
                    if (wr_ptr_q == len_q - LEN_W'(1)) begin
                        state_d     = S_HEADER;
                        data_out_d  = mk_header(len_q, dest_q);
                        pkt_valid_d = 1'b1;
                    end
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (!busy) begin
                    if (rd_ptr_q == len_q) begin
                        state_d     = S_PARITY;
                        data_out_d  = parity_q;
                        pkt_valid_d = 1'b0;
                    end else begin
                        state_d    = S_PAYLOAD;
                        data_out_d = buf_rd;
                        rd_ptr_d   = rd_ptr_q + LEN_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d    = S_GAP;
                    data_out_d = '0;
                    gap_d      = '0;
                    pkt_done_d = 1'b1;
                    pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gap_d = gap_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            dest_q      <= '0;
            parity_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            gap_q       <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            drop_q      <= 1'b0;
            err_prev_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            parity_q    <= parity_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            gap_q       <= gap_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_done_q  <= pkt_done_d;
            drop_q      <= drop_d;
            err_prev_q  <= err_prev_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign pay_ready = (state_q == S_LOAD);
    assign data_out  = data_out_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_done  = pkt_done_q;
    assign drop      = drop_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: scoreboard bench for the router packet source
module tb_router_pkt_src;
    localparam int CNT_W = 4;

    logic             clock = 1'b0, reset = 1'b1;
    logic             req_valid = 1'b0, req_ready;
    logic [1:0]       req_dest = '0;
    logic [5:0]       req_len = '0;
    logic [7:0]       pay_data = '0;
    logic             pay_valid = 1'b0, pay_ready;
    logic [7:0]       data_out;
    logic             pkt_valid, busy = 1'b0, err = 1'b0, pkt_done, drop;
    logic [CNT_W-1:0] pkt_cnt, err_cnt;

    router_pkt_src #(.GAP_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_len(req_len), .pay_data(pay_data), .pay_valid(pay_valid),
        .pay_ready(pay_ready), .data_out(data_out), .pkt_valid(pkt_valid), .busy(busy),
        .err(err), .pkt_done(pkt_done), .drop(drop), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_buf[64];
    bit         in_pkt;
    int         hold, nbyte, hdr_hold, done_seen, exp_pkts;
    string      tag;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: a presented byte is accepted at the next rising edge if busy is low
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            in_pkt = 0;
            hold = 0;
            nbyte = 0;
        end else begin
            if (pkt_done) done_seen++;
            if (pkt_valid) in_pkt = 1;
            if (in_pkt) begin
                hold++;
                if (!busy) begin
                    if (!pkt_valid) tag = "parity";
                    else if (nbyte == 0) tag = "header";
                    else tag = "payload";
                    if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
                    else chk(tag, data_out, exp_q.pop_front());
                    if (nbyte == 0) hdr_hold = hold;
                    hold = 0;
                    nbyte++;
                    if (!pkt_valid) begin
                        in_pkt = 0;
                        nbyte = 0;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [1:0] dest, input logic [5:0] len, input bit tog,
                            input int busy_n, input int rst_at);
        logic [7:0] par;
        int g, d0, gaps, bad, i, c;
        bit acc;
        d0 = done_seen;
        if (dest != 2'd3) begin
            par = {len, dest};
            exp_q.push_back(par);
            for (int k = 0; k < int'(len); k++) begin
                exp_q.push_back(pay_buf[k]);
                par ^= pay_buf[k];
            end
            exp_q.push_back(par);
        end
        req_dest = dest;
        req_len = len;
        req_valid = 1'b1;
        g = 0;
        do begin
            acc = req_ready;
            @(posedge clock); #1;
            g++;
        end while (!acc && g < 20);
        req_valid = 1'b0;
        chk("req_accept", acc, 1);
        if (dest == 2'd3) begin
            chk("drop_pulse", drop, 1);
            bad = 0;
            pay_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (pay_ready || pkt_valid || (k > 0 && drop)) bad++;
                @(posedge clock); #1;
            end
            pay_valid = 1'b0;
            chk("drop_quiet", bad, 0);
            chk("drop_pkt_cnt", pkt_cnt, exp_pkts[CNT_W-1:0]);
            return;
        end
        chk("no_drop", drop, 0);
        i = 0;
        c = 0;
        while (i < int'(len) && c < 1000) begin
            pay_valid = tog ? ~c[0] : 1'b1;
            pay_data = pay_buf[i];
            acc = pay_valid && pay_ready;
            @(posedge clock); #1;
            c++;
            if (acc) i++;
        end
        pay_valid = 1'b0;
        chk("pay_loaded", i, int'(len));
        if (busy_n > 0) begin
            g = 0;
            while (!pkt_valid && g < 20) begin
                @(posedge clock); #1;
                g++;
            end
            busy = 1'b1;
            repeat (busy_n) begin
                @(posedge clock); #1;
            end
            busy = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at) begin
                @(posedge clock); #1;
            end
            chk("pre_rst_valid", pkt_valid, 1);
            #2 reset = 1'b1;
            #1;
            chk("rst_pkt_valid", pkt_valid, 0);
            chk("rst_data_out", data_out, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pay_ready", pay_ready, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
            @(posedge clock); #1;
            reset = 1'b0;
            #1;
            chk("post_rst_req_ready", req_ready, 1);
            exp_pkts = 0;
            return;
        end
        g = 0;
        while (!pkt_done && g < 400) begin
            @(posedge clock); #1;
            g++;
        end
        chk("pkt_done_seen", pkt_done, 1);
        exp_pkts++;
        chk("pkt_cnt", pkt_cnt, exp_pkts[CNT_W-1:0]);
        gaps = 0;
        bad = 0;
        while (!req_ready && gaps < 10) begin
            if (pkt_valid || data_out != 8'h00) bad++;
            gaps++;
            @(posedge clock); #1;
        end
        chk("gap_cycles", gaps, 2);
        chk("gap_idle", bad, 0);
        chk("done_pulses", done_seen - d0, 1);
        chk("sb_empty", exp_q.size(), 0);
        chk("hdr_hold", hdr_hold, busy_n + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready0", req_ready, 0);
        chk("rst_pay_ready0", pay_ready, 0);
        chk("rst_pkt_valid0", pkt_valid, 0);
        chk("rst_data_out0", data_out, 0);
        chk("rst_pkt_done0", pkt_done, 0);
        chk("rst_drop0", drop, 0);
        chk("rst_pkt_cnt0", pkt_cnt, 0);
        chk("rst_err_cnt0", err_cnt, 0);
        reset = 1'b0;
        #1;
        chk("idle_req_ready", req_ready, 1);

        pay_buf[0] = 8'hA1;
        pay_buf[1] = 8'hB2;
        pay_buf[2] = 8'hC3;
        send_pkt(2'd1, 6'd3, 0, 0, 0);
        send_pkt(2'd1, 6'd3, 0, 2, 0);
        send_pkt(2'd2, 6'd0, 0, 0, 0);
        send_pkt(2'd3, 6'd5, 0, 0, 0);
        for (int k = 0; k < 64; k++) pay_buf[k] = 8'($urandom);
        send_pkt(2'd0, 6'd63, 1, 0, 0);

        while (exp_pkts < 16) begin
            for (int k = 0; k < 8; k++) pay_buf[k] = 8'($urandom);
            send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(0, 6)), 0, 0, 0);
        end
        chk("pkt_cnt_wrap", pkt_cnt, 0);

        for (int k = 0; k < 64; k++) pay_buf[k] = 8'($urandom);
        send_pkt(2'd0, 6'd63, 0, 0, 5);
        pay_buf[0] = 8'h5A;
        pay_buf[1] = 8'h3C;
        send_pkt(2'd2, 6'd2, 1, 1, 0);

        @(posedge clock); #1;
        err = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
        end
        err = 1'b0;
        @(posedge clock); #1;
        err = 1'b1;
        @(posedge clock); #1;
        err = 1'b0;
        @(posedge clock); #1;
        chk("err_cnt", err_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
